irq_ctl: RTL and testbench

Memory-mapped interrupt controller sitting on the 65C02 core's bus, acting as the bus responder to the core's address/write cycles and as the source of the core's `irq` input. Eight interrupt sources are latched (edge or level mode per source), masked, and priority-encoded. The block returns register read data with the same one-cycle latency as synchronous RAM. During IRQ/BRK vector fetches from $FFFE/$FFFF it supplies a per-source vector that overrides the default ROM vector.

---
 rtl/irq_ctl.sv | 180 ++++++++++++++++++
 tb/tb_irq_ctl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : irq_ctl
//  Description : Memory-mapped 8-source interrupt controller for a 65C02 bus.
//                Latches sources (edge or level per bit), masks them,
//                priority-encodes them (bit 0 highest), drives the core's irq,
//                and overrides the IRQ/BRK vector fetch at VEC_LO/VEC_LO+1
//                with a per-source vector taken from a table at VB + 2*index.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk      in   1  clock
//    reset    in   1  synchronous, active-high reset
//    AB       in  16  core address bus (current cycle)
//    DO       in   8  core write data (valid with AB when WE=1)
//    WE       in   1  core write strobe
//    src      in   8  interrupt sources, synchronous to clk
//    irq      out  1  registered level interrupt request
//    DI       out  8  registered read data (one-cycle latency)
//    sel      out  1  DI carries register-window data this cycle
//    vec_sel  out  1  DI carries vector data this cycle
//  Register map (offset from BASE)
//    0 STAT (W1C)  1 MASK  2 MODE (1=edge)  3 SWSET (W1S, reads 0)
//    4 CUR (RO)    5 VBL   6 VBH            7 reserved
// ============================================================================
module irq_ctl #(
    parameter logic [15:0] BASE   = 16'hFE00,
    parameter logic [15:0] VEC_LO = 16'hFFFE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] AB,
    input  logic [7:0]  DO,
    input  logic        WE,
    input  logic [7:0]  src,
    output logic        irq,
    output logic [7:0]  DI,
    output logic        sel,
    output logic        vec_sel
);

    localparam logic [2:0] OFF_STAT  = 3'd0;
    localparam logic [2:0] OFF_MASK  = 3'd1;
    localparam logic [2:0] OFF_MODE  = 3'd2;
    localparam logic [2:0] OFF_SWSET = 3'd3;
    localparam logic [2:0] OFF_CUR   = 3'd4;
    localparam logic [2:0] OFF_VBL   = 3'd5;
    localparam logic [2:0] OFF_VBH   = 3'd6;

    logic [7:0]  pending;
    logic [7:0]  mask;
    logic [7:0]  mode;
    logic [7:0]  src_d;
    logic [15:0] vb;
    logic [2:0]  vidx;
    logic        vvalid;

    logic        win_hit;
    logic [2:0]  offs;
    logic        win_wr;
    logic        win_rd;
    logic [7:0]  sw_set;
    logic [7:0]  stat_clr;
    logic [7:0]  set_vec;
    logic [7:0]  pending_nx;
    logic [7:0]  masked;
    logic        active;
    logic [2:0]  cur_idx;
    logic [7:0]  cur_val;
    logic [7:0]  rd_data;
    logic        vec_lo_rd;
    logic        vec_hi_rd;
    logic [15:0] vec_lo_addr;
    logic [15:0] vec_hi_addr;

    assign win_hit = (AB[15:3] == BASE[15:3]);
    assign offs    = AB[2:0];
    assign win_wr  = win_hit & WE;
    assign win_rd  = win_hit & ~WE;

    assign sw_set   = (win_wr && offs == OFF_SWSET) ? DO : 8'h00;
    assign stat_clr = (win_wr && offs == OFF_STAT)  ? DO : 8'h00;

    // Edge bits fire on a rising edge against the registered copy; level bits
    // fire whenever the source is high. Any set condition beats a same-cycle
    // W1C clear so an event arriving during a clear is never lost.
    assign set_vec    = (mode & src & ~src_d) | (~mode & src) | sw_set;
    assign pending_nx = set_vec | (pending & ~stat_clr);

    assign masked = pending & mask;
    assign active = |masked;

    // Lowest-numbered masked pending bit wins; scan downward so the last
    // assignment is the lowest index.
    always_comb begin
        cur_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (masked[i]) begin
                cur_idx = 3'(i);
            end
        end
    end

    assign cur_val = active ? {5'b00000, cur_idx} : 8'h80;

    always_comb begin
        rd_data = 8'h00;
        case (offs)
            OFF_STAT: rd_data = pending;
            OFF_MASK: rd_data = mask;
            OFF_MODE: rd_data = mode;
            OFF_CUR:  rd_data = cur_val;
            OFF_VBL:  rd_data = vb[7:0];
            OFF_VBH:  rd_data = vb[15:8];
            default:  rd_data = 8'h00;
        endcase
    end

    assign vec_lo_rd = ~WE && (AB == VEC_LO);
    assign vec_hi_rd = ~WE && (AB == (VEC_LO + 16'd1));

    // Low byte uses the live CUR index (it is latched in the same cycle);
    // the high byte uses the latched index so both halves match even if
    // pending changes between the two fetches.
    assign vec_lo_addr = vb + {12'h000, cur_idx, 1'b0};
    assign vec_hi_addr = vb + {12'h000, vidx, 1'b0};

    always_ff @(posedge clk) begin
        // Tracks src even in reset so a source held high through reset
        // does not look like a rising edge afterwards.
        src_d <= src;
        if (reset) begin
            pending <= 8'h00;
            mask    <= 8'h00;
            mode    <= 8'hFF;
            vb      <= 16'hFF00;
            vidx    <= 3'd0;
            vvalid  <= 1'b0;
            irq     <= 1'b0;
            DI      <= 8'h00;
            sel     <= 1'b0;
            vec_sel <= 1'b0;
        end else begin
            pending <= pending_nx;
            irq     <= active;

            if (win_wr) begin
                case (offs)
                    OFF_MASK: mask     <= DO;
                    OFF_MODE: mode     <= DO;
                    OFF_VBL:  vb[7:0]  <= DO;
                    OFF_VBH:  vb[15:8] <= DO;
                    default:  ;
                endcase
            end

            DI      <= 8'h00;
            sel     <= 1'b0;
            vec_sel <= 1'b0;
            if (win_rd) begin
                DI  <= rd_data;
                sel <= 1'b1;
            end else if (vec_lo_rd) begin
                if (active) begin
                    vidx    <= cur_idx;
                    vvalid  <= 1'b1;
                    DI      <= vec_lo_addr[7:0];
                    vec_sel <= 1'b1;
                end else begin
                    vvalid  <= 1'b0;
                end
            end else if (vec_hi_rd && vvalid) begin
                DI      <= vec_hi_addr[15:8];
                vec_sel <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_irq_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_irq_ctl
//  Description : Self-checking bench for irq_ctl. Expected read results are
//                queued when a bus cycle is driven and popped when the
//                registered response appears one cycle later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_ctl;

    localparam logic [15:0] A_STAT  = 16'hFE00;
    localparam logic [15:0] A_MASK  = 16'hFE01;
    localparam logic [15:0] A_MODE  = 16'hFE02;
    localparam logic [15:0] A_SWSET = 16'hFE03;
    localparam logic [15:0] A_CUR   = 16'hFE04;
    localparam logic [15:0] A_VBL   = 16'hFE05;
    localparam logic [15:0] A_VBH   = 16'hFE06;
    localparam logic [15:0] A_RSV   = 16'hFE07;
    localparam logic [15:0] A_IDLE  = 16'h0200;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] AB;
    logic [7:0]  DO;
    logic        WE;
    logic [7:0]  src;
    logic        irq;
    logic [7:0]  DI;
    logic        sel;
    logic        vec_sel;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string      nm;
        logic [7:0] di;
        logic       s;
        logic       vs;
        logic       care;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    irq_ctl #(.BASE(16'hFE00), .VEC_LO(16'hFFFE)) dut (
        .clk     (clk),
        .reset   (reset),
        .AB      (AB),
        .DO      (DO),
        .WE      (WE),
        .src     (src),
        .irq     (irq),
        .DI      (DI),
        .sel     (sel),
        .vec_sel (vec_sel)
    );

    always #5 clk = ~clk;

    // Called at a falling edge: presents one bus cycle, returns at the next
    // falling edge where that cycle's registered response is visible.
    task automatic bus(input logic [15:0] a, input logic w, input logic [7:0] d);
        AB = a;
        WE = w;
        DO = d;
        @(negedge clk);
        AB = A_IDLE;
        WE = 1'b0;
        DO = 8'h00;
    endtask

    task automatic push(input string nm, input logic [7:0] di, input logic s,
                        input logic vs, input logic care);
        exp_t x;
        x.nm = nm; x.di = di; x.s = s; x.vs = vs; x.care = care;
        sb.push_back(x);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        src   = 8'h00;
        bus(A_MODE, 1'b0, 8'h00);
        bus(A_IDLE, 1'b0, 8'h00);
        n_checks++;
        if ({irq, sel, vec_sel, DI} !== 11'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: irq=%b sel=%b vec_sel=%b DI=%h, expected all 0",
                     irq, sel, vec_sel, DI);
        end
        reset = 1'b0;
        push("rd_mode_rst", 8'hFF, 1'b1, 1'b0, 1'b1);
        push("rd_vbh_rst",  8'hFF, 1'b1, 1'b0, 1'b1);
        push("rd_swset",    8'h00, 1'b1, 1'b0, 1'b1);
        push("rd_rsv",      8'h00, 1'b1, 1'b0, 1'b1);
        push("rd_cur_none", 8'h80, 1'b1, 1'b0, 1'b1);
        foreach (sb[k]) begin end
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: bus(A_MODE,  1'b0, 8'h00);
                1: bus(A_VBH,   1'b0, 8'h00);
                2: bus(A_SWSET, 1'b0, 8'h00);
                3: bus(A_RSV,   1'b0, 8'h00);
                default: bus(A_CUR, 1'b0, 8'h00);
            endcase
            e = sb.pop_front();
            n_checks++;
            if ({sel, vec_sel} !== {e.s, e.vs} || (e.care && DI !== e.di)) begin
                n_fail++;
                $display("FAIL %s: sel=%b vec_sel=%b DI=%h, expected sel=%b vec_sel=%b DI=%h",
                         e.nm, sel, vec_sel, DI, e.s, e.vs, e.di);
            end
        end
        bus(A_IDLE, 1'b0, 8'h00);
        n_checks++;
        if (sel !== 1'b0) begin
            n_fail++;
            $display("FAIL sel_after_miss: sel=%b, expected 0", sel);
        end
    endtask

    task automatic test_edge();
        bus(A_MASK, 1'b1, 8'h04);
        src = 8'h04;
        bus(A_IDLE, 1'b0, 8'h00);   // pending[2] sets at this edge
        src = 8'h00;
        bus(A_IDLE, 1'b0, 8'h00);   // irq registers the active request
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL edge_irq: irq=%b, expected 1", irq);
        end
        push("rd_cur_2", 8'h02, 1'b1, 1'b0, 1'b1);
        bus(A_CUR, 1'b0, 8'h00);
        e = sb.pop_front();
        n_checks++;
        if ({sel, vec_sel} !== {e.s, e.vs} || (e.care && DI !== e.di)) begin
            n_fail++;
            $display("FAIL %s: sel=%b vec_sel=%b DI=%h, expected sel=%b vec_sel=%b DI=%h",
                     e.nm, sel, vec_sel, DI, e.s, e.vs, e.di);
        end
        bus(A_STAT, 1'b1, 8'h04);
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_irq_hold: irq=%b, expected 1", irq);
        end
        bus(A_IDLE, 1'b0, 8'h00);
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_irq_drop: irq=%b, expected 0", irq);
        end
    endtask

    task automatic test_vector();
        bus(A_MASK,  1'b1, 8'hFF);
        bus(A_VBL,   1'b1, 8'hFE);
        bus(A_VBH,   1'b1, 8'h12);
        bus(A_SWSET, 1'b1, 8'h28);
        push("rd_cur_3", 8'h03, 1'b1, 1'b0, 1'b1);
        push("vec_lo",   8'h04, 1'b0, 1'b1, 1'b1);
        push("vec_hi",   8'h13, 1'b0, 1'b1, 1'b1);
        push("vec_we",   8'h00, 1'b0, 1'b0, 1'b0);
        push("rd_stat",  8'h28, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: bus(A_CUR,    1'b0, 8'h00);
                1: bus(16'hFFFE, 1'b0, 8'h00);
                2: bus(16'hFFFF, 1'b0, 8'h00);
                3: bus(16'hFFFE, 1'b1, 8'h00);
                default: bus(A_STAT, 1'b0, 8'h00);
            endcase
            e = sb.pop_front();
            n_checks++;
            if ({sel, vec_sel} !== {e.s, e.vs} || (e.care && DI !== e.di)) begin
                n_fail++;
                $display("FAIL %s: sel=%b vec_sel=%b DI=%h, expected sel=%b vec_sel=%b DI=%h",
                         e.nm, sel, vec_sel, DI, e.s, e.vs, e.di);
            end
        end
        bus(A_STAT, 1'b1, 8'hFF);
    endtask

    task automatic test_collision();
        src = 8'h01;
        bus(A_STAT, 1'b1, 8'h01);   // rising edge and clear in the same cycle
        src = 8'h00;
        push("collide_stat", 8'h01, 1'b1, 1'b0, 1'b1);
        bus(A_STAT, 1'b0, 8'h00);
        e = sb.pop_front();
        n_checks++;
        if ({sel, vec_sel} !== {e.s, e.vs} || (e.care && DI !== e.di)) begin
            n_fail++;
            $display("FAIL %s: sel=%b vec_sel=%b DI=%h, expected sel=%b vec_sel=%b DI=%h",
                     e.nm, sel, vec_sel, DI, e.s, e.vs, e.di);
        end
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL collide_irq: irq=%b, expected 1", irq);
        end
        bus(A_STAT, 1'b1, 8'h01);
        bus(A_IDLE, 1'b0, 8'h00);
    endtask

    task automatic test_level();
        bus(A_MODE, 1'b1, 8'h00);
        src = 8'h02;
        bus(A_IDLE, 1'b0, 8'h00);
        bus(A_STAT, 1'b1, 8'h02);   // source still high: clear cannot stick
        push("level_held", 8'h02, 1'b1, 1'b0, 1'b1);
        bus(A_STAT, 1'b0, 8'h00);
        e = sb.pop_front();
        n_checks++;
        if ({sel, vec_sel} !== {e.s, e.vs} || (e.care && DI !== e.di)) begin
            n_fail++;
            $display("FAIL %s: sel=%b vec_sel=%b DI=%h, expected sel=%b vec_sel=%b DI=%h",
                     e.nm, sel, vec_sel, DI, e.s, e.vs, e.di);
        end
        src = 8'h00;
        bus(A_STAT, 1'b1, 8'h02);
        push("level_clr", 8'h00, 1'b1, 1'b0, 1'b1);
        bus(A_STAT, 1'b0, 8'h00);
        e = sb.pop_front();
        n_checks++;
        if ({sel, vec_sel} !== {e.s, e.vs} || (e.care && DI !== e.di)) begin
            n_fail++;
            $display("FAIL %s: sel=%b vec_sel=%b DI=%h, expected sel=%b vec_sel=%b DI=%h",
                     e.nm, sel, vec_sel, DI, e.s, e.vs, e.di);
        end
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL level_irq: irq=%b, expected 0", irq);
        end
        bus(A_MODE, 1'b1, 8'hFF);
    endtask

    task automatic test_noactive_reset();
        bus(A_MASK,  1'b1, 8'h00);
        bus(A_SWSET, 1'b1, 8'h01);  // pending but masked out
        push("noact_lo", 8'h00, 1'b0, 1'b0, 1'b0);
        push("noact_hi", 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            bus((i == 0) ? 16'hFFFE : 16'hFFFF, 1'b0, 8'h00);
            e = sb.pop_front();
            n_checks++;
            if ({sel, vec_sel} !== {e.s, e.vs} || (e.care && DI !== e.di)) begin
                n_fail++;
                $display("FAIL %s: sel=%b vec_sel=%b DI=%h, expected sel=%b vec_sel=%b DI=%h",
                         e.nm, sel, vec_sel, DI, e.s, e.vs, e.di);
            end
        end
        bus(A_MASK, 1'b1, 8'hAA);
        reset = 1'b1;
        bus(A_SWSET, 1'b1, 8'hFF);
        reset = 1'b0;
        push("rst_stat", 8'h00, 1'b1, 1'b0, 1'b1);
        push("rst_mask", 8'h00, 1'b1, 1'b0, 1'b1);
        push("rst_vbl",  8'h00, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: bus(A_STAT, 1'b0, 8'h00);
                1: bus(A_MASK, 1'b0, 8'h00);
                default: bus(A_VBL, 1'b0, 8'h00);
            endcase
            e = sb.pop_front();
            n_checks++;
            if ({sel, vec_sel} !== {e.s, e.vs} || (e.care && DI !== e.di)) begin
                n_fail++;
                $display("FAIL %s: sel=%b vec_sel=%b DI=%h, expected sel=%b vec_sel=%b DI=%h",
                         e.nm, sel, vec_sel, DI, e.s, e.vs, e.di);
            end
        end
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_irq: irq=%b, expected 0", irq);
        end
    endtask

    initial begin
        reset = 1'b1;
        AB    = A_IDLE;
        DO    = 8'h00;
        WE    = 1'b0;
        src   = 8'h00;
        @(negedge clk);
        test_reset();
        test_edge();
        test_vector();
        test_collision();
        test_level();
        test_noactive_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
